fir_mac_sched: RTL and testbench
================================

Name: fir_mac_sched

Overview:
Time-multiplexed FIR controller that shares one external 8x8 signed Booth multiplier across all filter taps. It holds the coefficient bank and the sample delay line, and runs one multiply-accumulate per cycle through the multiplier. It presents each filtered result on a valid/ready output. It sits between the sample source and the downstream consumer in the FIR datapath. The multiplier is purely combinational and is instantiated outside this block.

Parameters:
OPERAND_SIZE, 8, width of samples and coefficients (two's complement).
NTAPS, 8, number of taps (power of two, 2..16).
ACC_W, 19, accumulator/result width; default is 2*OPERAND_SIZE + log2(NTAPS).
AW, 3, coefficient address width, log2(NTAPS).

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
coef_we  in  1  coefficient write strobe.
coef_addr  in  AW  coefficient index.
coef_data  in  OPERAND_SIZE  signed coefficient value.
in_valid  in  1  sample offered.
in_ready  out  1  block can accept a sample.
in_sample  in  OPERAND_SIZE  signed input sample.
mult_md  out  OPERAND_SIZE  multiplicand to the multiplier (coefficient).
mult_m  out  OPERAND_SIZE  multiplier operand (delayed sample).
mult_p  in  2*OPERAND_SIZE  signed product from the multiplier, same cycle.
out_valid  out  1  result available.
out_ready  in  1  consumer accepts the result.
out_data  out  ACC_W  signed filter output.
busy  out  1  high in the MAC and HOLD states.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - Coefficient bank, delay line, accumulator, tap counter and out_data clear to 0.
  - out_valid=0, busy=0, in_ready=1 (combinational from IDLE).
  - Reset asserted mid-MAC or in HOLD aborts the computation; no out_valid is produced.
- FSM states: IDLE, MAC, HOLD. in_ready = (state==IDLE). busy = !IDLE.
- IDLE:
  - coef_we=1 writes coef[coef_addr] <= coef_data at the clock edge.
  - On in_valid && in_ready: shift the delay line (x[0] <= in_sample, x[k] <= x[k-1]; x[NTAPS-1] is discarded), acc <= 0, tap <= 0, then go to MAC.
- MAC:
  - Each cycle: mult_md = coef[tap], mult_m = x[tap] (combinational from the registers).
  - At the edge: acc <= acc + signext(mult_p), tap <= tap+1.
  - On the edge where tap==NTAPS-1: out_data <= acc + signext(mult_p), out_valid <= 1, go to HOLD.
  - Exactly NTAPS MAC cycles per sample.
- HOLD: out_valid and out_data stay stable until out_ready=1. On out_valid && out_ready the edge clears out_valid and returns to IDLE. in_ready is therefore 1 in the following cycle.
- mult_md and mult_m are driven to 0 whenever state != MAC.
- Latency: sample accepted at edge E0 gives out_valid high after edge E(NTAPS). With out_ready held at 1, one sample is accepted every NTAPS+2 cycles.
- coef_we outside IDLE is ignored: the bank does not change and no error is flagged. This keeps the coefficients stable during a computation.
- Arithmetic is fully signed; the product is sign-extended from 2*OPERAND_SIZE to ACC_W. With the default ACC_W no overflow is possible. If ACC_W is smaller, the sum wraps modulo 2^ACC_W.
- The delay-line history persists across samples; it is cleared only by reset.
- in_valid held high while not ready: the sample is not consumed and in_sample must be held by the source. A simultaneous in_valid and out handshake in HOLD is not accepted until IDLE.

Test Plan:
- Impulse response: load coef[k]=k+1 (1..8), then feed samples 1,0,0,0,0,0,0,0 -> outputs 1,2,3,4,5,6,7,8 in order.
- Signed extremes: all coef=-128, feed -128 eight times -> eighth output = 131072 (0x20000); feed 127 with coef -128 after reset -> first output = -16256.
- Latency/throughput: accept at cycle 0 with out_ready=1 -> out_valid at cycle 8, in_ready=1 at cycle 9, next sample accepted at cycle 9 or later.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD with in_valid=1 -> out_data stable, in_ready=0, no sample consumed; release -> result taken, next sample accepted in IDLE.
- Coefficient write during MAC: write coef[0]=50 mid-computation -> current and following outputs use the old value; coefficient changes only when rewritten in IDLE.
- Reset mid-MAC: drop rst_n at MAC cycle 3 -> outputs 0, out_valid never asserts, delay line and coefficients read 0, in_ready=1 after release.

Source files
------------

// File: rtl/fir_mac_sched.sv
// Time-multiplexed FIR controller: one shared external multiplier, one MAC per cycle over NTAPS taps.
// Latency: sample accepted at edge E0 -> out_valid after edge E(NTAPS); throughput one sample per NTAPS+2 cycles.
// Backpressure: in_ready only in IDLE; result held in HOLD until out_ready, stalling further samples.
module fir_mac_sched #(
    parameter int OPERAND_SIZE = 8,
    parameter int NTAPS        = 8,
    parameter int ACC_W        = 19,
    parameter int AW           = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      coef_we,
    input  logic [AW-1:0]             coef_addr,
    input  logic [OPERAND_SIZE-1:0]   coef_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OPERAND_SIZE-1:0]   in_sample,
    output logic [OPERAND_SIZE-1:0]   mult_md,
    output logic [OPERAND_SIZE-1:0]   mult_m,
    input  logic [2*OPERAND_SIZE-1:0] mult_p,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          out_data,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);

    state_t                   state;
    logic [OPERAND_SIZE-1:0]  coef [NTAPS];
    logic [OPERAND_SIZE-1:0]  x    [NTAPS];
    logic signed [ACC_W-1:0]  acc;
    logic [AW-1:0]            tap;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_next;
    logic                     accept;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && (state == IDLE);

    // Operands only reach the shared multiplier while a MAC is in progress.
    assign mult_md  = (state == MAC) ? coef[tap] : '0;
    assign mult_m   = (state == MAC) ? x[tap]    : '0;

    // Product sign-extended to accumulator width; narrower ACC_W wraps.
    assign prod_ext = ACC_W'($signed(mult_p));
    assign acc_next = acc + prod_ext;

    // Coefficient bank: writable only in IDLE so a running computation sees stable taps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) coef[i] <= '0;
        end else if (coef_we && (state == IDLE)) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // Delay line: shifts once per accepted sample; history survives across samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) x[i] <= '0;
        end else if (accept) begin
            x[0] <= in_sample;
            for (int i = 1; i < NTAPS; i++) x[i] <= x[i-1];
        end
    end

    // Sequencer: accept in IDLE, NTAPS MAC cycles, hold the result until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            tap       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= '0;
                        tap   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    tap <= tap + 1'b1;
                    if (tap == LAST_TAP) begin
                        out_data  <= acc_next;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Bench for fir_mac_sched: behavioural convolution model plus an external combinational multiplier.
// Latency: checks first-result timing and NTAPS+2 throughput with out_ready held high.
// Backpressure: exercises HOLD stalls, mid-MAC coefficient writes and mid-MAC reset.
module tb_fir_mac_sched;

    localparam int OS    = 8;
    localparam int NT    = 8;
    localparam int AWD   = 3;
    localparam int ACCW  = 19;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              coef_we;
    logic [AWD-1:0]    coef_addr;
    logic [OS-1:0]     coef_data;
    logic              in_valid;
    logic              in_ready;
    logic [OS-1:0]     in_sample;
    logic [OS-1:0]     mult_md;
    logic [OS-1:0]     mult_m;
    logic [2*OS-1:0]   mult_p;
    logic              out_valid;
    logic              out_ready;
    logic [ACCW-1:0]   out_data;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: plain integer taps and sample history.
    int coef_m [NT];
    int hist   [NT];

    always #5 clk = ~clk;

    // The shared multiplier lives outside the block.
    assign mult_p = $signed(mult_md) * $signed(mult_m);

    fir_mac_sched #(.OPERAND_SIZE(OS), .NTAPS(NT), .ACC_W(ACCW), .AW(AWD)) dut (
        .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_sample(in_sample), .mult_md(mult_md), .mult_m(mult_m), .mult_p(mult_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    function automatic logic [ACCW-1:0] model_y();
        longint s = 0;
        for (int k = 0; k < NT; k++) s += longint'(coef_m[k]) * longint'(hist[k]);
        return ACCW'(s);
    endfunction

    function automatic void model_push(input int s);
        for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = s;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < NT; k++) begin
            coef_m[k] = 0;
            hist[k]   = 0;
        end
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
    endtask

    task automatic write_coef(input int a, input int d);
        coef_we = 1'b1; coef_addr = AWD'(a); coef_data = OS'(d);
        @(posedge clk); #1;
        coef_we = 1'b0;
        coef_m[a] = int'($signed(OS'(d)));
    endtask

    task automatic send_sample(input int s, output bit ok);
        int n = 0;
        in_sample = OS'(s); in_valid = 1'b1;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        ok = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (ok) model_push(int'($signed(OS'(s))));
    endtask

    task automatic get_output(input int delay, output logic [ACCW-1:0] d, output bit ok);
        int n = 0;
        out_ready = 1'b0;
        while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
        ok = out_valid; d = out_data;
        repeat (delay) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            n_bad++; $display("FAIL reset_flags got %b want 100", {in_ready, busy, out_valid});
        end
        n_cmp++;
        if (out_data !== '0 || mult_md !== '0 || mult_m !== '0) begin
            n_bad++; $display("FAIL reset_data got out=%h md=%h m=%h want 0", out_data, mult_md, mult_m);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_impulse();
        bit ok, ok2;
        logic [ACCW-1:0] d;
        do_reset();
        for (int k = 0; k < NT; k++) write_coef(k, k + 1);
        for (int n = 0; n < NT; n++) begin
            send_sample((n == 0) ? 1 : 0, ok);
            get_output(0, d, ok2);
            n_cmp++;
            if (!ok || !ok2 || d !== ACCW'(n + 1) || d !== model_y()) begin
                n_bad++; $display("FAIL impulse[%0d] got %0d want %0d (hs %b%b)", n, $signed(d), n + 1, ok, ok2);
            end
        end
    endtask

    task automatic test_extremes();
        bit ok, ok2;
        logic [ACCW-1:0] d;
        do_reset();
        for (int k = 0; k < NT; k++) write_coef(k, -128);
        for (int n = 0; n < NT; n++) begin
            send_sample(-128, ok);
            get_output(0, d, ok2);
            n_cmp++;
            if (!ok || !ok2 || d !== model_y()) begin
                n_bad++; $display("FAIL extreme_acc[%0d] got %0d want %0d", n, $signed(d), $signed(model_y()));
            end
        end
        n_cmp++;
        if (d !== ACCW'(131072)) begin
            n_bad++; $display("FAIL extreme_max got %0d want 131072", $signed(d));
        end
        do_reset();
        for (int k = 0; k < NT; k++) write_coef(k, -128);
        send_sample(127, ok);
        get_output(0, d, ok2);
        n_cmp++;
        if (!ok || !ok2 || d !== ACCW'(-16256)) begin
            n_bad++; $display("FAIL extreme_neg got %0d want -16256", $signed(d));
        end
    endtask

    task automatic test_latency();
        int first_vld = -1;
        logic [ACCW-1:0] exp;
        do_reset();
        for (int k = 0; k < NT; k++) write_coef(k, $urandom_range(255));
        out_ready = 1'b1;
        in_sample = OS'($urandom_range(255)); in_valid = 1'b1;
        n_cmp++;
        if (!in_ready) begin n_bad++; $display("FAIL lat_ready got 0 want 1"); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_push(int'($signed(in_sample)));
        exp = model_y();
        for (int k = 0; k <= NT; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (out_valid && first_vld < 0) first_vld = k;
            if (k < NT) begin
                n_cmp++;
                if (mult_md !== OS'(coef_m[k]) || mult_m !== OS'(hist[k]) || !busy) begin
                    n_bad++; $display("FAIL lat_operands[%0d] got md=%h m=%h busy=%b want md=%h m=%h busy=1",
                                      k, mult_md, mult_m, busy, OS'(coef_m[k]), OS'(hist[k]));
                end
            end
        end
        n_cmp++;
        if (first_vld !== NT || out_data !== exp) begin
            n_bad++; $display("FAIL lat_first got cyc=%0d data=%0d want cyc=%0d data=%0d",
                              first_vld, $signed(out_data), NT, $signed(exp));
        end
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL lat_return got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok, ok2;
        int n = 0;
        logic [ACCW-1:0] d0, d1;
        do_reset();
        for (int k = 0; k < NT; k++) write_coef(k, $urandom_range(255));
        out_ready = 1'b0;
        send_sample($urandom_range(255), ok);
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        d0 = out_data;
        n_cmp++;
        if (!ok || !out_valid || d0 !== model_y()) begin
            n_bad++; $display("FAIL bp_first got %0d want %0d", $signed(d0), $signed(model_y()));
        end
        in_sample = OS'($urandom_range(255)); in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_data !== d0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_bad++; $display("FAIL bp_hold[%0d] got data=%0d rdy=%b vld=%b want data=%0d rdy=0 vld=1",
                                  c, $signed(out_data), in_ready, out_valid, $signed(d0));
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL bp_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_push(int'($signed(in_sample)));
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL bp_accept got busy=%b want 1", busy); end
        get_output(0, d1, ok2);
        n_cmp++;
        if (!ok2 || d1 !== model_y()) begin
            n_bad++; $display("FAIL bp_second got %0d want %0d", $signed(d1), $signed(model_y()));
        end
    endtask

    task automatic test_coef_during_mac();
        bit ok, ok2;
        logic [ACCW-1:0] d;
        do_reset();
        for (int k = 0; k < NT; k++) write_coef(k, 7 - k);
        for (int r = 0; r < 2; r++) begin
            send_sample(3 + r, ok);
            coef_we = 1'b1; coef_addr = '0; coef_data = OS'(50);
            repeat (3) begin @(posedge clk); #1; end
            coef_we = 1'b0;
            get_output(0, d, ok2);
            n_cmp++;
            if (!ok || !ok2 || d !== model_y()) begin
                n_bad++; $display("FAIL coef_mac[%0d] got %0d want %0d", r, $signed(d), $signed(model_y()));
            end
        end
        write_coef(0, 50);
        send_sample(-9, ok);
        get_output(0, d, ok2);
        n_cmp++;
        if (!ok || !ok2 || d !== model_y()) begin
            n_bad++; $display("FAIL coef_idle got %0d want %0d", $signed(d), $signed(model_y()));
        end
    endtask

    task automatic test_reset_mid_mac();
        bit ok, ok2, seen = 0;
        logic [ACCW-1:0] d;
        do_reset();
        for (int k = 0; k < NT; k++) write_coef(k, $urandom_range(1, 100));
        send_sample(77, ok);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 ||
            mult_md !== '0 || mult_m !== '0) begin
            n_bad++; $display("FAIL rst_mac_now got rdy=%b busy=%b vld=%b data=%0d want 1 0 0 0",
                              in_ready, busy, out_valid, out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        out_ready = 1'b0;
        n_cmp++;
        if (seen || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL rst_mac_novalid got seen=%b rdy=%b want seen=0 rdy=1", seen, in_ready);
        end
        // All-zero coefficients after reset: any sample gives 0.
        send_sample(55, ok);
        get_output(0, d, ok2);
        n_cmp++;
        if (!ok || !ok2 || d !== '0) begin
            n_bad++; $display("FAIL rst_mac_coef got %0d want 0", $signed(d));
        end
        // Unit taps over a zero sample expose the history: only the post-reset 55 survives.
        for (int k = 0; k < NT; k++) write_coef(k, 1);
        send_sample(0, ok);
        get_output(0, d, ok2);
        n_cmp++;
        if (!ok || !ok2 || d !== ACCW'(55) || d !== model_y()) begin
            n_bad++; $display("FAIL rst_mac_hist got %0d want 55", $signed(d));
        end
    endtask

    task automatic test_random();
        bit ok, ok2;
        logic [ACCW-1:0] d;
        do_reset();
        for (int k = 0; k < NT; k++) write_coef(k, $urandom_range(255));
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(3) == 0) write_coef($urandom_range(NT - 1), $urandom_range(255));
            send_sample($urandom_range(255), ok);
            get_output($urandom_range(4), d, ok2);
            n_cmp++;
            if (!ok || !ok2 || d !== model_y()) begin
                n_bad++; $display("FAIL random[%0d] got %0d want %0d", n, $signed(d), $signed(model_y()));
            end
        end
    endtask

    initial begin
        rst_n = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        in_valid = 1'b0; in_sample = '0; out_ready = 1'b0;
        model_clear();
        test_reset();
        test_impulse();
        test_extremes();
        test_latency();
        test_backpressure();
        test_coef_during_mac();
        test_reset_mid_mac();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout after %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
